// File: rtl/pipe_ctrl_if.sv
// Bundles the request side (stall sources, flush, counter clear) and the control
// outputs of the pipeline controller into one port.
interface pipe_ctrl_if #(
    parameter int NSTAGE = 6,
    parameter int NREQ   = 2,
    parameter int CNT_W  = 32
);
    logic [NREQ-1:0]   stallreq;
    logic              flush_req;
    logic [31:0]       flush_pc;
    logic              cnt_clr;

    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;
    logic              hang;

    // The master side raises requests; the controller is the slave.
    modport master (
        output stallreq, flush_req, flush_pc, cnt_clr,
        input  stall, flush, new_pc, stall_cycles, flush_count, hang
    );

    modport slave (
        input  stallreq, flush_req, flush_pc, cnt_clr,
        output stall, flush, new_pc, stall_cycles, flush_count, hang
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges per-source stall requests and a flush request into
// the stall bus, flush strobe and redirect PC, with perf counters and a hang watchdog.
module pipe_ctrl #(
    parameter int                NSTAGE     = 6,
    parameter int                NREQ       = 2,
    parameter logic [NREQ*4-1:0] REQ_STAGE  = {4'd3, 4'd2},
    parameter bit                REG_FLUSH  = 1'b0,
    parameter int                CNT_W      = 32,
    parameter int                HANG_LIMIT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] HANG_MAX = CNT_W'(HANG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NSTAGE-1:0] w_req_stall;
    logic              w_flush_src;
    logic [31:0]       w_new_pc_src;
    logic              w_flush;
    logic [31:0]       w_new_pc;
    logic [NSTAGE-1:0] w_stall;
    logic [CNT_W-1:0]  w_streak_nxt;

    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic [CNT_W-1:0]  r_streak;
    logic              r_hang;

    // Each active source stalls stages 0..REQ_STAGE[i]; an out-of-range field
    // simply saturates to the whole bus.
    always_comb begin
        // NOTE: every variable gets a default first so this block can never infer a latch.
        w_req_stall = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.stallreq[i]) begin
                for (int k = 0; k < NSTAGE; k++) begin
                    if (int'(REQ_STAGE[i*4 +: 4]) >= k) begin
                        w_req_stall[k] = 1'b1;
                    end
                end
            end
        end
    end

    generate
        if (REG_FLUSH) begin : g_reg_flush
            logic        r_flush;
            logic [31:0] r_new_pc;

            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_flush  <= 1'b0;
                    r_new_pc <= '0;
                end else begin
                    r_flush  <= bus.flush_req;
                    r_new_pc <= bus.flush_req ? bus.flush_pc : 32'h0;
                end
            end

            assign w_flush_src  = r_flush;
            assign w_new_pc_src = r_new_pc;
        end else begin : g_comb_flush
            assign w_flush_src  = bus.flush_req;
            assign w_new_pc_src = bus.flush_req ? bus.flush_pc : 32'h0;
        end
    endgenerate

    // Reset masks every control output combinationally; flush beats any stall.
    assign w_flush  = rst ? 1'b0 : w_flush_src;
    assign w_new_pc = w_flush ? w_new_pc_src : 32'h0;
    assign w_stall  = (rst || w_flush) ? '0 : w_req_stall;

    always_comb begin
        w_streak_nxt = r_streak;
        if (w_stall == '0) begin
            w_streak_nxt = '0;
        end else if (r_streak != HANG_MAX) begin
            w_streak_nxt = r_streak + 1'b1;
        end
    end

    // Counter clear shares priority with reset so it wins over any increment.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_streak       <= '0;
            r_hang         <= 1'b0;
        end else begin
            if ((w_stall != '0) && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_flush && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
            r_streak <= w_streak_nxt;
            if (w_streak_nxt == HANG_MAX) begin
                r_hang <= 1'b1;
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.new_pc       = w_new_pc;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
    assign bus.hang         = r_hang;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the multi-stage core. It merges per-stage stall requests and a flush request into the stall bus, flush strobe and redirect PC consumed by the IF/ID/EX/MEM/WB stages. It is the generalised successor of the fixed two-source controller, adding:
- configurable stage and source counts;
- optional registered flush;
- stall/flush performance counters;
- a hang watchdog.

Parameters:
NSTAGE, 6, width of stall bus; bit 0 = PC, bit 1 = IF, bit 2 = ID, … bit NSTAGE-1 = WB
NREQ, 2, number of stall request sources
REQ_STAGE, {4'd3,4'd2}, packed NREQ×4-bit vector; field i = stage index that source i stalls up to (inclusive), valid range 0..NSTAGE-1
REG_FLUSH, 0, 0 = flush/new_pc combinational from flush_req; 1 = registered, one cycle later
CNT_W, 32, perf counter width
HANG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (≥1, < 2^CNT_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stallreq  in  NREQ  per-source stall request, level, sampled every cycle
flush_req  in  1  flush/redirect request, single-cycle pulse from the resolving stage
flush_pc  in  32  redirect target, valid with flush_req
cnt_clr  in  1  synchronous clear of perf counters and watchdog
stall  out  NSTAGE  stall bus to all stages
flush  out  1  flush strobe to all stages
new_pc  out  32  redirect PC to IF, valid while flush=1
stall_cycles  out  CNT_W  cycles with any stall bit set
flush_count  out  CNT_W  number of flush strobes issued
hang  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge):
  - stall_cycles, flush_count, streak counter and hang are cleared to 0.
  - The REG_FLUSH=1 flush/new_pc registers are cleared to 0.
  - While rst=1, stall=all-zero, flush=0 and new_pc=0, combinationally and irrespective of inputs.
- Stall merge (combinational, same cycle):
  - For each source i with stallreq[i]=1, set stall[0..REQ_STAGE[i]] to 1.
  - stall is the OR over all sources, so it is always a contiguous low-order run of ones.
  - Stages insert a bubble where stall[k]=1 and stall[k+1]=0; that is the stage's job, not this block's.
- Flush, REG_FLUSH=0:
  - flush = flush_req and new_pc = flush_pc, same cycle.
  - While flush=1, stall is forced to all-zero regardless of stallreq (flush has priority).
  - new_pc = 0 whenever flush=0.
- Flush, REG_FLUSH=1:
  - On flush_req at edge N, flush=1 and new_pc=flush_pc are presented during cycle N+1, for exactly one cycle.
  - stall is forced to zero in the cycle flush=1.
  - A flush_req arriving in the same cycle flush=1 is captured normally and produces a second strobe the following cycle.
- Perf counters:
  - stall_cycles increments at each edge where post-priority stall≠0.
  - flush_count increments at each edge where flush=1.
  - Both saturate at all-ones (no wrap).
  - cnt_clr=1 clears both to 0 at the edge; the clear wins over a simultaneous increment.
- Watchdog:
  - The streak counter increments on each edge where stall≠0 and clears on any edge where stall=0.
  - When streak reaches HANG_LIMIT, hang sets and stays set until rst or cnt_clr.
  - The streak counter saturates at HANG_LIMIT.
- Reset mid-stall or mid-flush: all state drops the next edge; the pending registered flush is discarded.
- Per source i: REQ_STAGE[i] ≥ NSTAGE is a configuration error. Only the low NSTAGE bits of that source's mask are used; no assertion is required.

Test Plan:
1. Defaults, reset held 3 cycles with stallreq=2'b11, flush_req=1 → stall=6'b000000, flush=0, counters=0. After release with stallreq=2'b01 → stall=6'b000111; stall_cycles=1 after one edge.
2. stallreq=2'b11 → stall=6'b001111. Drop stallreq[1] → stall=6'b000111 the same cycle. Drop all → stall=0; stall_cycles stays at its count.
3. REG_FLUSH=0, stallreq=2'b10 with flush_req=1, flush_pc=32'hBFC0_0380 in the same cycle → stall=0, flush=1, new_pc=32'hBFC0_0380 that cycle; flush_count=1 after the edge.
4. REG_FLUSH=1, flush_req pulse at cycle 5 with flush_pc=32'h8000_0100 → flush=1 and new_pc=32'h8000_0100 in cycle 6 only. Back-to-back pulses in cycles 5 and 6 → flush high in cycles 6 and 7; flush_count=2.
5. HANG_LIMIT=8, stallreq=2'b01 held 8 cycles → hang=1 after the 8th edge and remains 1 after stallreq drops. Repeat with a 1-cycle stall gap at cycle 5 → hang stays 0.
6. CNT_W=4, stall held 20 cycles → stall_cycles saturates at 4'hF. cnt_clr=1 in the same cycle as a stalled cycle → stall_cycles=0 and hang=0 next cycle.
